// File: rtl/pla_vector_sweeper.sv
// Stimulus sweeper and response capture for a combinational PLA core.
// Walks an inclusive vector range, counting onsets and signing the responses.
module pla_vector_sweeper #(
    parameter int          N_IN     = 21,
    parameter logic [31:0] SIG_SEED = 32'h0000_0000,
    parameter logic [31:0] SIG_POLY = 32'h04C1_1DB7
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [N_IN-1:0] cfg_first,
    input  logic [N_IN-1:0] cfg_last,
    output logic [N_IN-1:0] vec_out,
    output logic            vec_valid,
    input  logic            vec_ready,
    input  logic            y_in,
    output logic            busy,
    output logic            done,
    output logic [N_IN:0]   onset_count,
    output logic [31:0]     signature
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [N_IN-1:0] vec_q, vec_d;
    logic [N_IN-1:0] last_q, last_d;
    logic [N_IN:0]   cnt_q, cnt_d;
    logic [31:0]     sig_q, sig_d;
    logic            fb;

    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        sig_d   = sig_q;
        fb      = sig_q[31] ^ y_in;
        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    vec_d   = cfg_first;
                    last_d  = cfg_last;
                    cnt_d   = '0;
                    sig_d   = SIG_SEED;
                    state_d = (cfg_first > cfg_last) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (vec_ready) begin
                    cnt_d = cnt_q + {{N_IN{1'b0}}, y_in};
                    sig_d = {sig_q[30:0], 1'b0} ^ (fb ? SIG_POLY : 32'h0);
                    // Compare before incrementing so an all-ones last never wraps
                    if (vec_q == last_q) begin
                        state_d = S_DONE;
                    end else begin
                        vec_d = vec_q + 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            vec_q   <= '0;
            last_q  <= '0;
            cnt_q   <= '0;
            sig_q   <= SIG_SEED;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            sig_q   <= sig_d;
        end
    end

    assign vec_out     = vec_q;
    assign vec_valid   = (state_q == S_RUN);
    assign busy        = (state_q == S_RUN);
    assign done        = (state_q == S_DONE);
    assign onset_count = cnt_q;
    assign signature   = sig_q;

endmodule

// File: tb/tb_pla_vector_sweeper.sv
// Scoreboard bench for pla_vector_sweeper: range model feeds queues,
// a negedge monitor pops and compares transfers and final results.
module tb_pla_vector_sweeper;

    localparam int          N      = 21;
    localparam int          VMAX   = (1 << N) - 1;
    localparam logic [31:0] SEED   = 32'h0000_0000;
    localparam logic [31:0] POLY   = 32'h04C1_1DB7;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [N-1:0]  cfg_first;
    logic [N-1:0]  cfg_last;
    logic [N-1:0]  vec_out;
    logic          vec_valid;
    logic          vec_ready;
    logic          y_in;
    logic          busy;
    logic          done;
    logic [N:0]    onset_count;
    logic [31:0]   signature;

    int checks   = 0;
    int failures = 0;
    int ymode    = 0;
    int rmode    = 0;
    int rphase   = 0;
    logic [N-1:0] ymask = '0;

    logic [N-1:0] exp_vec[$];
    logic [N:0]   exp_cnt[$];
    logic [31:0]  exp_sig[$];

    logic         armed = 1'b0;
    logic         pstall = 1'b0;
    logic [N-1:0] pvec = '0;

    pla_vector_sweeper dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .cfg_first   (cfg_first),
        .cfg_last    (cfg_last),
        .vec_out     (vec_out),
        .vec_valid   (vec_valid),
        .vec_ready   (vec_ready),
        .y_in        (y_in),
        .busy        (busy),
        .done        (done),
        .onset_count (onset_count),
        .signature   (signature)
    );

    always #5 clk = ~clk;

    // Stand-in for the PLA core: a combinational function of vec_out
    always_comb begin
        y_in = 1'b0;
        case (ymode)
            0:       y_in = vec_out[0];
            1:       y_in = 1'b1;
            2:       y_in = 1'b0;
            default: y_in = ^(vec_out & ymask);
        endcase
    end

    function automatic logic yf(input logic [N-1:0] v);
        case (ymode)
            0:       return v[0];
            1:       return 1'b1;
            2:       return 1'b0;
            default: return ^(v & ymask);
        endcase
    endfunction

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Reference: every vector in [f,l] once, in order, then final totals
    task automatic expect_sweep(input int f, input int l);
        logic [N:0]  cnt = '0;
        logic [31:0] sig = SEED;
        logic        y;
        for (int v = f; v <= l; v++) begin
            y = yf(v[N-1:0]);
            exp_vec.push_back(v[N-1:0]);
            cnt = cnt + {{N{1'b0}}, y};
            sig = {sig[30:0], 1'b0} ^ ((sig[31] ^ y) ? POLY : 32'h0);
        end
        exp_cnt.push_back(cnt);
        exp_sig.push_back(sig);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            rphase++;
            case (rmode)
                0:       vec_ready = 1'b1;
                1:       vec_ready = (rphase % 3 == 0);
                default: vec_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                armed  = 1'b0;
                pstall = 1'b0;
            end else begin
                if (pstall) begin
                    chk("stall_valid", vec_valid, 1);
                    chk("stall_vec", vec_out, pvec);
                end
                if (vec_valid && vec_ready) begin
                    if (exp_vec.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_xfer actual=%0h required=none",
                                 vec_out);
                    end else begin
                        chk("xfer_vec", vec_out, exp_vec.pop_front());
                    end
                end
                if (armed && done) begin
                    armed = 1'b0;
                    if (exp_cnt.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_done actual=1 required=0");
                    end else begin
                        chk("onset_count", onset_count, exp_cnt.pop_front());
                        chk("signature", signature, exp_sig.pop_front());
                    end
                end
                if (start && !busy) armed = 1'b1;
                pstall = vec_valid && !vec_ready;
                pvec   = vec_out;
            end
        end
    end

    task automatic sweep(input int f, input int l, input int ym,
                         input int rm, input bit poke);
        int n = 0;
        int bound;
        ymode = ym;
        rmode = rm;
        ymask = N'($urandom);
        expect_sweep(f, l);
        bound = ((l >= f) ? (l - f + 1) : 0) * 4 + 8;
        cfg_first = f[N-1:0];
        cfg_last  = l[N-1:0];
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("valid_after_start", vec_valid, (f <= l));
        if (f <= l) chk("first_vec", vec_out, f);
        while (!done && n < bound) begin
            start = (poke && n == 3);
            if (poke && n == 3) begin
                cfg_first = 21'd20;
                cfg_last  = 21'd25;
            end
            @(posedge clk);
            #1;
            start = 1'b0;
            n++;
        end
        chk("done_seen", done, 1);
        chk("busy_after_done", busy, 0);
        if (rm == 0) chk("done_latency", n, (f <= l) ? (l - f + 1) : 0);
        if (!done) begin
            exp_vec.delete();
            exp_cnt.delete();
            exp_sig.delete();
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int f;
        int l;
        int wait_n;
        rst       = 1'b1;
        start     = 1'b0;
        cfg_first = '0;
        cfg_last  = '0;
        vec_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_vec", vec_out, 0);
        chk("rst_valid", vec_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_cnt", onset_count, 0);
        chk("rst_sig", signature, SEED);

        sweep(0, 3, 0, 0, 0);
        chk("t1_cnt", onset_count, 2);

        sweep(5, 5, 1, 0, 0);
        chk("t2_sig1", signature, 32'h04C1_1DB7);
        chk("t2_cnt1", onset_count, 1);
        sweep(5, 5, 2, 0, 0);
        chk("t2_sig0", signature, 32'h0);
        chk("t2_cnt0", onset_count, 0);

        sweep(0, 7, 0, 1, 0);

        sweep(9, 4, 0, 0, 0);
        chk("t4_cnt", onset_count, 0);

        sweep(VMAX - 1, VMAX, 1, 0, 0);
        chk("t5_cnt", onset_count, 2);
        chk("t5_hold_last", vec_out, VMAX);
        sweep(VMAX - 4095, VMAX, 1, 0, 0);
        chk("t5_top_cnt", onset_count, 4096);

        // Reset in the middle of a sweep discards everything
        ymode = 0;
        rmode = 0;
        expect_sweep(0, 10);
        cfg_first = '0;
        cfg_last  = 21'd10;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_n = 0;
        while (vec_out != 3 && wait_n < 20) begin
            @(posedge clk);
            #1;
            wait_n++;
        end
        chk("reach_vec3", vec_out, 3);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_vec.delete();
        void'(exp_cnt.pop_back());
        void'(exp_sig.pop_back());
        chk("mid_rst_vec", vec_out, 0);
        chk("mid_rst_valid", vec_valid, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_cnt", onset_count, 0);
        chk("mid_rst_sig", signature, SEED);

        sweep(0, 10, 3, 1, 1);
        sweep(2, 6, 0, 0, 0);

        repeat (8) begin
            f = int'($urandom_range(0, VMAX));
            if ($urandom_range(0, 4) == 0 && f > 0) begin
                l = int'($urandom_range(0, f - 1));
            end else begin
                l = f + int'($urandom_range(0, 30));
                if (l > VMAX) l = VMAX;
            end
            sweep(f, l, 3, 2, 0);
        end

        repeat (3) @(posedge clk);
        chk("vec_queue_drained", exp_vec.size(), 0);
        chk("result_queue_drained", exp_cnt.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pla_vector_sweeper.md
Name: pla_vector_sweeper

Overview:
- Sequential stimulus-and-capture stage placed directly upstream of a combinational PLA evaluation core (21 inputs x0..x20, single output y0).
- Sweeps an inclusive range of input vectors and presents each one to the core with a valid/ready handshake.
- For every accepted vector, samples the core's output; accumulates an onset count and a 32-bit signature.
- Used for equivalence checks between original and optimised netlists.

Parameters:
- N_IN, 21, width of the input vector driven to the core (bit i drives x<i>).
- SIG_SEED, 32'h00000000, reset/start value of the signature register.
- SIG_POLY, 32'h04C11DB7, feedback polynomial of the signature LFSR.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse; begins a sweep when idle or done.
- cfg_first  input  N_IN  first vector of the sweep; sampled on an accepted start.
- cfg_last  input  N_IN  last vector of the sweep, inclusive; sampled on an accepted start.
- vec_out  output  N_IN  current vector to the core.
- vec_valid  output  1  vec_out is valid.
- vec_ready  input  1  core/consumer accepts vec_out this cycle.
- y_in  input  1  core output for the current vec_out, combinational, same cycle.
- busy  output  1  high while in RUN.
- done  output  1  high in DONE until the next accepted start or reset.
- onset_count  output  N_IN+1  number of accepted vectors with y_in=1.
- signature  output  32  LFSR signature over the accepted y_in sequence.

Behaviour:
- Reset (rst=1 at edge) forces state IDLE and these outputs:
  - vec_out=0, vec_valid=0, busy=0, done=0
  - onset_count=0, signature=SIG_SEED
- Reset mid-sweep has the same effect; no partial results are retained.
- States are IDLE, RUN and DONE.
- IDLE or DONE, start=1:
  - latch first/last; clear onset_count to 0 and signature to SIG_SEED; clear done.
  - if first>last (unsigned): go to DONE next cycle with count 0; no vector is issued.
  - otherwise: go to RUN with vec_out=first, vec_valid=1, busy=1.
- RUN, start is ignored.
- Handshake: a transfer occurs on a cycle with vec_valid & vec_ready.
  - vec_out and vec_valid are held stable while vec_valid=1 and vec_ready=0.
- On each transfer:
  - onset_count += y_in.
  - signature: fb = signature[31] ^ y_in; signature_next = (signature << 1) ^ (fb ? SIG_POLY : 0).
- On a transfer where vec_out==last: go to DONE next cycle.
  - vec_valid=0, busy=0, done=1; vec_out holds last.
- On a transfer where vec_out!=last: vec_out+1 next cycle, vec_valid stays 1.
  - This gives 1 vector/cycle throughput when vec_ready is held high.
- The last-vector comparison is made before the increment, so last = all-ones (2^N_IN - 1) never wraps vec_out to 0.
- onset_count has N_IN+1 bits and saturates never; a full sweep of 2^N_IN ones fits.
- y_in is ignored outside transfer cycles.
- DONE: outputs hold. start re-arms as in IDLE (start and done-clear take effect in the same edge).
- Latency:
  - start to first vec_valid is 1 cycle.
  - last transfer to done is 1 cycle.
  - onset_count and signature are final in the cycle done rises.

Test Plan:
- Reset, then start with first=0, last=3, vec_ready=1, y_in=vec_out[0]:
  - vectors 0,1,2,3 on consecutive cycles.
  - done rises 1 cycle after vector 3; onset_count=2.
- SIG_SEED=0, first=last=5, y_in=1:
  - exactly one transfer; signature=0x04C11DB7, onset_count=1.
  - repeat with y_in=0: signature=0x00000000, onset_count=0.
- first=0, last=7, vec_ready toggling 1,0,0,1,...:
  - vec_out stable during stall cycles.
  - each vector is transferred exactly once; 8 transfers total, checked by scoreboard.
- first=9, last=4:
  - done=1 one cycle after start; vec_valid never asserts; onset_count=0.
- first=0x1FFFFE, last=0x1FFFFF, y_in=1:
  - exactly 2 transfers, no wrap to 0; onset_count=2.
  - full sweep first=0, last=0x1FFFFF, y_in=1 gives onset_count=0x200000.
- Assert rst during RUN at vector 3 of 0..10:
  - next cycle all outputs are at reset values, state IDLE.
  - a start during RUN is ignored; a new start then runs cleanly from cfg_first.
